spi_slave_param: RTL and testbench



---
 rtl/spi_slave_param_if.sv | 27 ++
 rtl/spi_slave_param.sv | 168 ++++++++++++++++
 tb/tb_spi_slave_param.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_slave_param_if.sv
// SPI pins plus RAM-side receive/transmit bundle for spi_slave_param.
interface spi_slave_param_if #(
    parameter int DATA_W = 8
);
    localparam int FRAME_W = DATA_W + 2;

    logic               SS_n;
    logic               MOSI;
    logic               MISO;
    logic [FRAME_W-1:0] rx_data;
    logic               rx_valid;
    logic [DATA_W-1:0]  tx_data;
    logic               tx_valid;
    logic               read_pending;
    logic               busy;
    logic               frame_err;

    modport slave (
        input  SS_n, MOSI, tx_data, tx_valid,
        output MISO, rx_data, rx_valid, read_pending, busy, frame_err
    );

    modport master (
        output SS_n, MOSI, tx_data, tx_valid,
        input  MISO, rx_data, rx_valid, read_pending, busy, frame_err
    );
endinterface

// File: rtl/spi_slave_param.sv
// Parametrised SPI slave front-end for the single-port RAM subsystem.
// Define SPI_SLV_FRAME_ERR_EN to build the aborted-frame detector.
module spi_slave_param #(
    parameter int DATA_W    = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    spi_slave_param_if.slave  bus
);
    localparam int FRAME_W = DATA_W + 2;
    localparam int CNT_W   = $clog2(FRAME_W + 1);
    localparam int TXC_W   = $clog2(DATA_W + 1);

    typedef enum logic [2:0] {
        IDLE,
        CHK_CMD,
        WRITE,
        READ_ADDR,
        READ_DATA
    } state_t;

    state_t             cs_q, cs_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [FRAME_W-1:0] rx_data_q, rx_data_d;
    logic               rx_valid_q, rx_valid_d;
    logic               rd_pend_q, rd_pend_d;
    logic               miso_q, miso_d;
    logic [DATA_W-1:0]  tx_sh_q, tx_sh_d;
    logic [TXC_W-1:0]   tx_cnt_q, tx_cnt_d;
    logic               tx_act_q, tx_act_d;
    logic               tx_done_q, tx_done_d;
    logic               rx_phase;
    logic               store;
    int                 pos;

    assign rx_phase = (cs_q == WRITE || cs_q == READ_ADDR ||
                       cs_q == READ_DATA) && (cnt_q != '0);

`ifdef SPI_SLV_FRAME_ERR_EN
    logic ferr_q, ferr_d;
    logic tx_short;

    // Shift-out cut short before every payload bit left the slave
    assign tx_short = (cs_q == READ_DATA) && tx_act_q && (tx_cnt_q != '0);
`endif

    always_comb begin
        cs_d       = cs_q;
        cnt_d      = cnt_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        rd_pend_d  = rd_pend_q;
        miso_d     = miso_q;
        tx_sh_d    = tx_sh_q;
        tx_cnt_d   = tx_cnt_q;
        tx_act_d   = tx_act_q;
        tx_done_d  = tx_done_q;
        store      = 1'b0;
        pos        = 0;
`ifdef SPI_SLV_FRAME_ERR_EN
        ferr_d     = 1'b0;
`endif
        if (cs_q != IDLE && bus.SS_n) begin
            cs_d      = IDLE;
            cnt_d     = '0;
            miso_d    = 1'b0;
            tx_act_d  = 1'b0;
            tx_done_d = 1'b0;
`ifdef SPI_SLV_FRAME_ERR_EN
            ferr_d    = rx_phase || tx_short;
`endif
        end else begin
            unique case (cs_q)
                IDLE: begin
                    if (!bus.SS_n) cs_d = CHK_CMD;
                end
                CHK_CMD: begin
                    store = 1'b1;
                    pos   = MSB_FIRST ? FRAME_W - 1 : 0;
                    cnt_d = CNT_W'(FRAME_W - 1);
                    if (!bus.MOSI)    cs_d = WRITE;
                    else if (rd_pend_q) cs_d = READ_DATA;
                    else              cs_d = READ_ADDR;
                end
                WRITE, READ_ADDR, READ_DATA: begin
                    if (rx_phase) begin
                        store = 1'b1;
                        pos   = MSB_FIRST ? int'(cnt_q) - 1
                                          : FRAME_W - int'(cnt_q);
                        cnt_d = cnt_q - 1'b1;
                        if (cnt_q == CNT_W'(1)) begin
                            rx_valid_d = 1'b1;
                            if (cs_q == READ_ADDR) rd_pend_d = 1'b1;
                        end
                    end else if (cs_q == READ_DATA) begin
                        if (tx_act_q) begin
                            if (tx_cnt_q != '0) begin
                                miso_d   = MSB_FIRST ? tx_sh_q[DATA_W-1]
                                                     : tx_sh_q[0];
                                tx_sh_d  = MSB_FIRST ? tx_sh_q << 1
                                                     : tx_sh_q >> 1;
                                tx_cnt_d = tx_cnt_q - 1'b1;
                            end else begin
                                tx_act_d  = 1'b0;
                                tx_done_d = 1'b1;
                                rd_pend_d = 1'b0;
                            end
                        end else if (!tx_done_q && bus.tx_valid) begin
                            miso_d   = MSB_FIRST ? bus.tx_data[DATA_W-1]
                                                 : bus.tx_data[0];
                            tx_sh_d  = MSB_FIRST ? bus.tx_data << 1
                                                 : bus.tx_data >> 1;
                            tx_cnt_d = TXC_W'(DATA_W - 1);
                            tx_act_d = 1'b1;
                        end
                    end
                end
                default: cs_d = IDLE;
            endcase
        end
        for (int i = 0; i < FRAME_W; i++) begin
            if (store && i == pos) rx_data_d[i] = bus.MOSI;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cs_q       <= IDLE;
            cnt_q      <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            rd_pend_q  <= 1'b0;
            miso_q     <= 1'b0;
            tx_sh_q    <= '0;
            tx_cnt_q   <= '0;
            tx_act_q   <= 1'b0;
            tx_done_q  <= 1'b0;
        end else begin
            cs_q       <= cs_d;
            cnt_q      <= cnt_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            rd_pend_q  <= rd_pend_d;
            miso_q     <= miso_d;
            tx_sh_q    <= tx_sh_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_act_q   <= tx_act_d;
            tx_done_q  <= tx_done_d;
        end
    end

`ifdef SPI_SLV_FRAME_ERR_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ferr_q <= 1'b0;
        else        ferr_q <= ferr_d;
    end
    assign bus.frame_err = ferr_q;
`else
    assign bus.frame_err = 1'b0;
`endif

    assign bus.MISO         = miso_q;
    assign bus.rx_data      = rx_data_q;
    assign bus.rx_valid     = rx_valid_q;
    assign bus.read_pending = rd_pend_q;
    assign bus.busy         = (cs_q != IDLE);
endmodule

// File: tb/tb_spi_slave_param.sv
// Scoreboard bench: an MSB-first 8-bit slave and an LSB-first 16-bit slave.
module tb_spi_slave_param;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    spi_slave_param_if #(.DATA_W(8))  b1();
    spi_slave_param_if #(.DATA_W(16)) b2();

    spi_slave_param #(.DATA_W(8), .MSB_FIRST(1'b1)) u1 (
        .clk(clk), .rst_n(rst_n), .bus(b1)
    );
    spi_slave_param #(.DATA_W(16), .MSB_FIRST(1'b0)) u2 (
        .clk(clk), .rst_n(rst_n), .bus(b2)
    );

    int errs = 0;
    int checks = 0;
    int ferr1 = 0;
    int ferr2 = 0;
    int exp_ferr = 0;
    logic [17:0] q_rx1[$];
    logic [17:0] q_rx2[$];
    logic q_miso1[$];
    logic q_miso2[$];
    logic prv1_rxv = 1'b0, prv1_fe = 1'b0;
    logic prv2_rxv = 1'b0, prv2_fe = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (b1.rx_valid) begin
            chk("rx1_pulse_width", 32'(prv1_rxv), 0);
            if (q_rx1.size() != 0)
                chk("rx1_data", 32'(b1.rx_data), 32'(q_rx1.pop_front()));
            else
                chk("rx1_spurious_valid", 32'(b1.rx_valid), 0);
        end
        prv1_rxv = b1.rx_valid;
        if (b1.frame_err) begin
            chk("ferr1_pulse_width", 32'(prv1_fe), 0);
            ferr1++;
        end
        prv1_fe = b1.frame_err;
        if (q_miso1.size() != 0)
            chk("miso1_bit", 32'(b1.MISO), 32'(q_miso1.pop_front()));
    end

    always @(posedge clk) begin
        #1;
        if (b2.rx_valid) begin
            chk("rx2_pulse_width", 32'(prv2_rxv), 0);
            if (q_rx2.size() != 0)
                chk("rx2_data", 32'(b2.rx_data), 32'(q_rx2.pop_front()));
            else
                chk("rx2_spurious_valid", 32'(b2.rx_valid), 0);
        end
        prv2_rxv = b2.rx_valid;
        if (b2.frame_err) begin
            chk("ferr2_pulse_width", 32'(prv2_fe), 0);
            ferr2++;
        end
        prv2_fe = b2.frame_err;
        if (q_miso2.size() != 0)
            chk("miso2_bit", 32'(b2.MISO), 32'(q_miso2.pop_front()));
    end

    function automatic logic pend(input int sel);
        return (sel == 0) ? b1.read_pending : b2.read_pending;
    endfunction

    function automatic logic busy(input int sel);
        return (sel == 0) ? b1.busy : b2.busy;
    endfunction

    function automatic logic miso(input int sel);
        return (sel == 0) ? b1.MISO : b2.MISO;
    endfunction

    task automatic set_ss(input int sel, input logic v);
        if (sel == 0) b1.SS_n = v;
        else          b2.SS_n = v;
    endtask

    task automatic set_mosi(input int sel, input logic v);
        if (sel == 0) b1.MOSI = v;
        else          b2.MOSI = v;
    endtask

    // Called at a negedge with the slave idle; returns at a negedge.
    task automatic frame(input int sel, input logic [17:0] f,
                         input int nsend, input bit rel);
        int fw;
        bit msb;
        fw  = (sel == 0) ? 10 : 18;
        msb = (sel == 0);
        if (nsend == fw) begin
            if (sel == 0) q_rx1.push_back(f);
            else          q_rx2.push_back(f);
        end
        set_ss(sel, 1'b0);
        @(negedge clk);
        for (int i = 0; i < nsend; i++) begin
            set_mosi(sel, msb ? f[fw-1-i] : f[i]);
            @(negedge clk);
        end
        if (rel) begin
            set_ss(sel, 1'b1);
            @(negedge clk);
        end
    endtask

    // Read-data shift-out; nb < data width aborts after nb bits.
    task automatic shift(input int sel, input logic [15:0] tx,
                         input int nb);
        int dw;
        bit msb;
        dw  = (sel == 0) ? 8 : 16;
        msb = (sel == 0);
        if (sel == 0) begin
            b1.tx_data = tx[7:0];
            b1.tx_valid = 1'b1;
        end else begin
            b2.tx_data = tx;
            b2.tx_valid = 1'b1;
        end
        for (int i = 0; i < nb; i++) begin
            if (sel == 0) q_miso1.push_back(msb ? tx[dw-1-i] : tx[i]);
            else          q_miso2.push_back(msb ? tx[dw-1-i] : tx[i]);
        end
        @(negedge clk);
        b1.tx_valid = 1'b0;
        b2.tx_valid = 1'b0;
        if (nb < dw) begin
            repeat (nb - 1) @(negedge clk);
            set_ss(sel, 1'b1);
            @(negedge clk);
            chk("abort_shift_pending", 32'(pend(sel)), 1);
        end else begin
            repeat (dw - 1) @(negedge clk);
            chk("pending_at_last_bit", 32'(pend(sel)), 1);
            @(negedge clk);
            chk("pending_cleared", 32'(pend(sel)), 0);
            chk("miso_hold", 32'(miso(sel)), 32'(msb ? tx[0] : tx[dw-1]));
            set_ss(sel, 1'b1);
            @(negedge clk);
        end
        chk("miso_idle_zero", 32'(miso(sel)), 0);
        chk("busy_idle", 32'(busy(sel)), 0);
    endtask

    initial begin
        b1.SS_n = 1'b1; b1.MOSI = 1'b0; b1.tx_valid = 1'b0; b1.tx_data = '0;
        b2.SS_n = 1'b1; b2.MOSI = 1'b0; b2.tx_valid = 1'b0; b2.tx_data = '0;
        repeat (3) @(negedge clk);
        chk("rst_rx_data", 32'(b1.rx_data), 0);
        chk("rst_busy", 32'(b1.busy), 0);
        chk("rst_pending", 32'(b1.read_pending), 0);
        chk("rst_miso", 32'(b1.MISO), 0);
        chk("rst_rx_valid", 32'(b1.rx_valid), 0);
        chk("rst_frame_err", 32'(b1.frame_err), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Write address frame, busy drops one cycle after SS_n rises
        frame(0, 18'h0A5, 10, 1'b0);
        chk("wr_busy_in_frame", 32'(b1.busy), 1);
        b1.SS_n = 1'b1;
        @(negedge clk);
        chk("wr_busy_after", 32'(b1.busy), 0);
        chk("wr_no_pending", 32'(b1.read_pending), 0);

        frame(0, 18'h210, 10, 1'b1);
        chk("rd_addr_pending", 32'(b1.read_pending), 1);

        // Write aborted after 5 bits keeps partial rx_data
        frame(0, 18'h0A0, 5, 1'b1);
`ifdef SPI_SLV_FRAME_ERR_EN
        exp_ferr++;
`endif
        chk("abort_rx_partial", 32'(b1.rx_data), 32'h0B0);
        chk("abort_pending_kept", 32'(b1.read_pending), 1);
        chk("abort_busy", 32'(b1.busy), 0);

        frame(0, 18'h300, 10, 1'b0);
        shift(0, 16'h00C3, 8);

        frame(0, 18'h2FF, 10, 1'b1);
        chk("rd_addr2_pending", 32'(b1.read_pending), 1);
        frame(0, 18'h3AA, 10, 1'b0);
        shift(0, 16'h0096, 3);
`ifdef SPI_SLV_FRAME_ERR_EN
        exp_ferr++;
`endif
        frame(0, 18'h300, 10, 1'b0);
        shift(0, 16'h005A, 8);

        // Asynchronous reset in the middle of a frame
        frame(0, 18'h201, 10, 1'b1);
        chk("pre_reset_pending", 32'(b1.read_pending), 1);
        frame(0, 18'h1C3, 4, 1'b0);
        chk("midframe_rx_partial", 32'(b1.rx_data), 32'h1C1);
        rst_n = 1'b0;
        #1;
        chk("areset_rx_data", 32'(b1.rx_data), 0);
        chk("areset_busy", 32'(b1.busy), 0);
        chk("areset_pending", 32'(b1.read_pending), 0);
        chk("areset_miso", 32'(b1.MISO), 0);
        chk("areset_rx_valid", 32'(b1.rx_valid), 0);
        b1.SS_n = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        frame(0, 18'h1C3, 10, 1'b1);
        chk("post_reset_rx", 32'(b1.rx_data), 32'h1C3);

        // LSB-first, 16-bit payload slave
        frame(1, 18'h12345, 18, 1'b1);
        chk("lsb_rx_data", 32'(b2.rx_data), 32'h12345);
        chk("lsb_pending", 32'(b2.read_pending), 1);
        frame(1, 18'h3FFFF, 18, 1'b0);
        shift(1, 16'hA5C3, 16);
        frame(1, 18'h24680, 18, 1'b1);
        chk("lsb_write_rx", 32'(b2.rx_data), 32'h24680);
        chk("lsb_write_no_pending", 32'(b2.read_pending), 0);

        repeat (3) @(negedge clk);
        chk("rx1_queue_drained", 32'(q_rx1.size()), 0);
        chk("rx2_queue_drained", 32'(q_rx2.size()), 0);
        chk("miso1_queue_drained", 32'(q_miso1.size()), 0);
        chk("miso2_queue_drained", 32'(q_miso2.size()), 0);
        chk("ferr1_count", 32'(ferr1), 32'(exp_ferr));
        chk("ferr2_count", 32'(ferr2), 0);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
